butterfly_param: RTL and testbench

BUTTERFLY_PARAM -- requirements
Module: butterfly_param

---
 rtl/butterfly_param.sv | 145 ++++++++++++++
 tb/tb_butterfly_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/butterfly_param.sv
// Pipelined radix-2 butterfly: Yp = Xp + W'*Xq, Yq = Xp - W'*Xq, with optional conj(W) and /2.
// Three register stages under a single elastic advance signal; saturation raises a sticky flag.
module butterfly_param #(
  parameter int DATA_W  = 24,
  parameter int TW_W    = 16,
  parameter int TW_FRAC = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] xp_real,
  input  logic signed [DATA_W-1:0] xp_imag,
  input  logic signed [DATA_W-1:0] xq_real,
  input  logic signed [DATA_W-1:0] xq_imag,
  input  logic signed [TW_W-1:0]   factor_real,
  input  logic signed [TW_W-1:0]   factor_imag,
  input  logic                     inv,
  input  logic                     scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] yp_real,
  output logic signed [DATA_W-1:0] yp_imag,
  output logic signed [DATA_W-1:0] yq_real,
  output logic signed [DATA_W-1:0] yq_imag,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int PW = DATA_W + TW_W;
  localparam int SW = PW + 2;

  localparam logic signed [DATA_W-1:0] MAX_OUT = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_OUT = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SW-1:0]     MAXV    = SW'(MAX_OUT);
  localparam logic signed [SW-1:0]     MINV    = SW'(MIN_OUT);
  localparam logic signed [SW-1:0]     ONE     = SW'(1);
  localparam logic signed [SW-1:0]     RND0    = ONE <<< (TW_FRAC - 1);
  localparam logic signed [SW-1:0]     RND1    = ONE <<< TW_FRAC;

  // Round half up, shift by TW_FRAC (+1 when scaling), then clamp to the output range.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [SW-1:0] v,
                                                         input logic scl,
                                                         output logic clamp);
    logic signed [SW-1:0] r;
    r = scl ? ((v + RND1) >>> (TW_FRAC + 1)) : ((v + RND0) >>> TW_FRAC);
    clamp = 1'b0;
    round_sat = $signed(r[DATA_W-1:0]);
    if (r > MAXV) begin
      clamp = 1'b1;
      round_sat = MAX_OUT;
    end else if (r < MINV) begin
      clamp = 1'b1;
      round_sat = MIN_OUT;
    end
  endfunction

  logic signed [PW-1:0]     rr_q, ii_q, ri_q, ir_q, xpr1_q, xpi1_q;
  logic signed [PW-1:0]     rr_d, ii_d, ri_d, ir_d, xpr1_d, xpi1_d;
  logic                     inv1_q, scale1_q, v1_q, inv1_d, scale1_d, v1_d;
  logic signed [SW-1:0]     re2_q, im2_q, xpr2_q, xpi2_q;
  logic signed [SW-1:0]     re2_d, im2_d, xpr2_d, xpi2_d;
  logic                     scale2_q, v2_q, scale2_d, v2_d;
  logic signed [DATA_W-1:0] ypr_q, ypi_q, yqr_q, yqi_q;
  logic signed [DATA_W-1:0] ypr_d, ypi_d, yqr_d, yqi_d;
  logic                     sat3_q, v3_q, ovf_q, sat3_d, v3_d, ovf_d;
  logic                     adv;

  assign adv       = out_ready | ~v3_q;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign yp_real   = ypr_q;
  assign yp_imag   = ypi_q;
  assign yq_real   = yqr_q;
  assign yq_imag   = yqi_q;
  assign ovf       = ovf_q;

  always_comb begin
    logic c0, c1, c2, c3;
    logic signed [DATA_W-1:0] n_ypr, n_ypi, n_yqr, n_yqi;

    rr_d = rr_q;  ii_d = ii_q;  ri_d = ri_q;  ir_d = ir_q;
    xpr1_d = xpr1_q;  xpi1_d = xpi1_q;
    inv1_d = inv1_q;  scale1_d = scale1_q;  v1_d = v1_q;
    re2_d = re2_q;  im2_d = im2_q;  xpr2_d = xpr2_q;  xpi2_d = xpi2_q;
    scale2_d = scale2_q;  v2_d = v2_q;
    ypr_d = ypr_q;  ypi_d = ypi_q;  yqr_d = yqr_q;  yqi_d = yqi_q;
    sat3_d = sat3_q;  v3_d = v3_q;

    n_ypr = round_sat(xpr2_q + re2_q, scale2_q, c0);
    n_ypi = round_sat(xpi2_q + im2_q, scale2_q, c1);
    n_yqr = round_sat(xpr2_q - re2_q, scale2_q, c2);
    n_yqi = round_sat(xpi2_q - im2_q, scale2_q, c3);

    if (adv) begin
      rr_d     = PW'(xq_real) * PW'(factor_real);
      ii_d     = PW'(xq_imag) * PW'(factor_imag);
      ri_d     = PW'(xq_real) * PW'(factor_imag);
      ir_d     = PW'(xq_imag) * PW'(factor_real);
      xpr1_d   = PW'(xp_real) <<< TW_FRAC;
      xpi1_d   = PW'(xp_imag) <<< TW_FRAC;
      inv1_d   = inv;
      scale1_d = scale;
      v1_d     = in_valid;

      // conj(W) negates the factor_imag terms: ii in the real part, ri in the imaginary part.
      re2_d    = inv1_q ? (SW'(rr_q) + SW'(ii_q)) : (SW'(rr_q) - SW'(ii_q));
      im2_d    = inv1_q ? (SW'(ir_q) - SW'(ri_q)) : (SW'(ir_q) + SW'(ri_q));
      xpr2_d   = SW'(xpr1_q);
      xpi2_d   = SW'(xpi1_q);
      scale2_d = scale1_q;
      v2_d     = v1_q;

      ypr_d  = n_ypr;
      ypi_d  = n_ypi;
      yqr_d  = n_yqr;
      yqi_d  = n_yqi;
      sat3_d = c0 | c1 | c2 | c3;
      v3_d   = v2_q;
    end

    ovf_d = (ovf_q & ~ovf_clr) | (v3_q & out_ready & sat3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;  ii_q <= '0;  ri_q <= '0;  ir_q <= '0;
      xpr1_q <= '0;  xpi1_q <= '0;
      inv1_q <= 1'b0;  scale1_q <= 1'b0;  v1_q <= 1'b0;
      re2_q <= '0;  im2_q <= '0;  xpr2_q <= '0;  xpi2_q <= '0;
      scale2_q <= 1'b0;  v2_q <= 1'b0;
      ypr_q <= '0;  ypi_q <= '0;  yqr_q <= '0;  yqi_q <= '0;
      sat3_q <= 1'b0;  v3_q <= 1'b0;  ovf_q <= 1'b0;
    end else begin
      rr_q <= rr_d;  ii_q <= ii_d;  ri_q <= ri_d;  ir_q <= ir_d;
      xpr1_q <= xpr1_d;  xpi1_q <= xpi1_d;
      inv1_q <= inv1_d;  scale1_q <= scale1_d;  v1_q <= v1_d;
      re2_q <= re2_d;  im2_q <= im2_d;  xpr2_q <= xpr2_d;  xpi2_q <= xpi2_d;
      scale2_q <= scale2_d;  v2_q <= v2_d;
      ypr_q <= ypr_d;  ypi_q <= ypi_d;  yqr_q <= yqr_d;  yqi_q <= yqi_d;
      sat3_q <= sat3_d;  v3_q <= v3_d;  ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_butterfly_param.sv
// Directed self-checking bench for butterfly_param with hand-computed expected results.
module tb_butterfly_param;

  localparam int DATA_W  = 24;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 13;

  logic                     clk = 1'b0;
  logic                     rst, in_valid, inv, scale, out_ready, ovf_clr;
  logic signed [DATA_W-1:0] xp_real, xp_imag, xq_real, xq_imag;
  logic signed [TW_W-1:0]   factor_real, factor_imag;
  logic                     in_ready, out_valid, ovf;
  logic signed [DATA_W-1:0] yp_real, yp_imag, yq_real, yq_imag;

  int errors = 0;
  int checks = 0;

  butterfly_param #(.DATA_W(DATA_W), .TW_W(TW_W), .TW_FRAC(TW_FRAC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .xp_real(xp_real), .xp_imag(xp_imag), .xq_real(xq_real), .xq_imag(xq_imag),
    .factor_real(factor_real), .factor_imag(factor_imag),
    .inv(inv), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .yp_real(yp_real), .yp_imag(yp_imag), .yq_real(yq_real), .yq_imag(yq_imag),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input longint xpr, input longint xpi, input longint xqr,
                               input longint xqi, input longint wr, input longint wi,
                               input logic iv, input logic sc);
    xp_real     = xpr[DATA_W-1:0];
    xp_imag     = xpi[DATA_W-1:0];
    xq_real     = xqr[DATA_W-1:0];
    xq_imag     = xqi[DATA_W-1:0];
    factor_real = wr[TW_W-1:0];
    factor_imag = wi[TW_W-1:0];
    inv         = iv;
    scale       = sc;
  endtask

  // One sample through an idle pipeline: transfer, two empty cycles, a one-cycle result.
  task automatic runSample(input string tag, input longint xpr, input longint xpi,
                           input longint xqr, input longint xqi, input longint wr,
                           input longint wi, input logic iv, input logic sc,
                           input longint eypr, input longint eypi,
                           input longint eyqr, input longint eyqi);
    applyStimulus(xpr, xpi, xqr, xqi, wr, wi, iv, sc);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, ".early"}, out_valid, 0);
    @(posedge clk); #1;
    checkOutput({tag, ".valid"}, out_valid, 1);
    checkOutput({tag, ".yp_re"}, yp_real, eypr);
    checkOutput({tag, ".yp_im"}, yp_imag, eypi);
    checkOutput({tag, ".yq_re"}, yq_real, eyqr);
    checkOutput({tag, ".yq_im"}, yq_imag, eyqi);
    @(posedge clk); #1;
    checkOutput({tag, ".pulse"}, out_valid, 0);
  endtask

  task automatic clearOvf(input string tag);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checkOutput({tag, ".ovf_clr"}, ovf, 0);
  endtask

  initial begin
    int  sent;
    int  recv;
    bit  fire_in;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.out_valid", out_valid, 0);
    checkOutput("rst.in_ready", in_ready, 1);
    checkOutput("rst.ovf", ovf, 0);
    checkOutput("rst.yp_re", yp_real, 0);
    checkOutput("rst.yq_im", yq_imag, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    runSample("basic", 100, 0, 50, 0, 8192, 0, 1'b0, 1'b0, 150, 0, 50, 0);
    runSample("rot", 0, 0, 1000, 0, 0, 8192, 1'b0, 1'b0, 0, 1000, 0, -1000);
    runSample("rot_inv", 0, 0, 1000, 0, 0, 8192, 1'b1, 1'b0, 0, -1000, 0, 1000);
    runSample("scale_pos", 3, 0, 0, 0, 8192, 0, 1'b0, 1'b1, 2, 0, 2, 0);
    runSample("scale_neg", -3, 0, 0, 0, 8192, 0, 1'b0, 1'b1, -1, 0, -1, 0);
    runSample("half_pos", 0, 0, 1, 0, 4096, 0, 1'b0, 1'b0, 1, 0, 0, 0);
    runSample("half_neg", 0, 0, -1, 0, 4096, 0, 1'b0, 1'b0, 0, 0, 1, 0);
    checkOutput("nosat.ovf", ovf, 0);

    runSample("sat_pos", 8388607, 5, 8388607, 0, 8192, 0, 1'b0, 1'b0, 8388607, 5, 0, 5);
    checkOutput("sat_pos.ovf", ovf, 1);
    @(posedge clk); #1;
    checkOutput("sat_pos.sticky", ovf, 1);
    clearOvf("sat_pos");

    runSample("sat_neg", -8388608, 0, -8388608, 0, 8192, 0, 1'b0, 1'b0, -8388608, 0, 0, 0);
    checkOutput("sat_neg.ovf", ovf, 1);
    clearOvf("sat_neg");

    // Most negative factor_imag with conj: W'*Xq = +2^38, far outside the output range.
    runSample("corner", 0, 0, 0, -8388608, 0, -32768, 1'b1, 1'b0, 8388607, 0, -8388608, 0);
    checkOutput("corner.ovf", ovf, 1);
    clearOvf("corner");

    // A clamp transferring in the same cycle as ovf_clr must leave ovf set.
    applyStimulus(8388607, 0, 8388607, 0, 8192, 0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("clr_race.valid", out_valid, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    checkOutput("clr_race.ovf", ovf, 1);

    // Three samples held in flight behind out_ready=0, then a one-cycle reset.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i + 1, 0, 1, 0, 8192, 0, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("midrst.full", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    checkOutput("midrst.out_valid", out_valid, 0);
    checkOutput("midrst.ovf", ovf, 0);
    checkOutput("midrst.in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("midrst.drained", out_valid, 0);
    end
    runSample("post_rst", 7, 0, 2, 0, 8192, 0, 1'b0, 1'b0, 9, 0, 5, 0);

    // Eight back-to-back samples with a five-cycle output stall in the middle.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      if (sent < 8) begin
        applyStimulus(sent * 10 + 1, 0, sent, 0, 8192, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(c >= 5 && c < 10);
      @(negedge clk);
      fire_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checkOutput("bp.yp", yp_real, recv * 11 + 1);
        checkOutput("bp.yq", yq_real, recv * 9 + 1);
        recv++;
      end else if (out_valid) begin
        checkOutput("bp.in_ready_low", in_ready, 0);
        checkOutput("bp.hold_yp", yp_real, recv * 11 + 1);
        checkOutput("bp.hold_yq", yq_real, recv * 9 + 1);
      end
      @(posedge clk); #1;
      if (fire_in) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp.count", recv, 8);
    @(posedge clk); #1;
    checkOutput("bp.idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
